// File: rtl/draw_square_if.sv
// Caller-side bus of the square drawer: start/size/colour request plus the
// VGA adapter pixel-write port the drawer owns while busy.
interface draw_square_if #(
    parameter int SIZE_W = 4
);
    logic              start;
    logic              done;
    logic              busy;
    logic [7:0]        x;
    logic [6:0]        y;
    logic [SIZE_W-1:0] size;
    logic [17:0]       colour;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;
    logic [17:0]       vga_colour;
    logic              vga_write;

    modport master (
        output start, x, y, size, colour,
        input  done, busy, vga_x, vga_y, vga_colour, vga_write
    );

    modport slave (
        input  start, x, y, size, colour,
        output done, busy, vga_x, vga_y, vga_colour, vga_write
    );
endinterface

// File: rtl/draw_square.sv
// Square pixel writer: one VGA write per clock, row-major, then a one-cycle done.
// Optional DRAW_SQUARE_CLIP_EN suppresses writes for off-screen pixels.
module draw_square #(
    parameter int SIZE_W   = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic         clock,
    input  logic         reset,
    draw_square_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t            state, state_d;
    logic [7:0]        x_l;
    logic [6:0]        y_l;
    logic [SIZE_W-1:0] size_l;
    logic [17:0]       colour_l;
    logic [SIZE_W-1:0] x_off, x_off_d, y_off, y_off_d, last_off;
    logic [7:0]        vga_x_q, vga_x_d;
    logic [6:0]        vga_y_q, vga_y_d;
    logic [17:0]       colour_q, colour_d;
    logic              write_q, write_d, done_q, done_d, busy_q, busy_d;
    logic [8:0]        sum_x;
    logic [7:0]        sum_y;

`ifdef DRAW_SQUARE_CLIP_EN
    function automatic logic on_screen(input logic [8:0] sx, input logic [7:0] sy);
        return (sx < 9'(SCREEN_W)) && (sy < 8'(SCREEN_H));
    endfunction
`else
    // Without clipping only the truncated sums are used.
    wire unused_clip = ^{sum_x[8], sum_y[7], 32'(SCREEN_W), 32'(SCREEN_H)};
`endif

    assign sum_x    = 9'(x_l) + 9'(x_off);
    assign sum_y    = 8'(y_l) + 8'(y_off);
    assign last_off = size_l - SIZE_W'(1);

    // Request fields are captured once; later input changes are ignored.
    always_ff @(posedge clock) begin
        if (state == IDLE && bus.start) begin
            x_l      <= bus.x;
            y_l      <= bus.y;
            size_l   <= bus.size;
            colour_l <= bus.colour;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            x_off   <= '0;
            y_off   <= '0;
            vga_x_q <= '0;
            vga_y_q <= '0;
            colour_q <= '0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_d;
            x_off   <= x_off_d;
            y_off   <= y_off_d;
            vga_x_q <= vga_x_d;
            vga_y_q <= vga_y_d;
            colour_q <= colour_d;
            write_q <= write_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d  = state;
        x_off_d  = x_off;
        y_off_d  = y_off;
        vga_x_d  = vga_x_q;
        vga_y_d  = vga_y_q;
        colour_d = colour_q;
        write_d  = 1'b0;
        done_d   = done_q;
        busy_d   = busy_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    x_off_d = '0;
                    y_off_d = '0;
                    busy_d  = 1'b1;
                    state_d = (bus.size == '0) ? DONE : DRAW;
                end
            end
            DRAW: begin
`ifdef DRAW_SQUARE_CLIP_EN
                write_d = on_screen(sum_x, sum_y);
                if (write_d) begin
                    vga_x_d  = sum_x[7:0];
                    vga_y_d  = sum_y[6:0];
                    colour_d = colour_l;
                end
`else
                write_d  = 1'b1;
                vga_x_d  = sum_x[7:0];
                vga_y_d  = sum_y[6:0];
                colour_d = colour_l;
`endif
                if (x_off == last_off) begin
                    x_off_d = '0;
                    if (y_off == last_off) begin
                        state_d = DONE;
                    end else begin
                        y_off_d = y_off + SIZE_W'(1);
                    end
                end else begin
                    x_off_d = x_off + SIZE_W'(1);
                end
            end
            DONE: begin
                // First DONE edge raises done; the second retires it and frees the port.
                if (!done_q) begin
                    done_d = 1'b1;
                end else begin
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = colour_q;
    assign bus.vga_write  = write_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
endmodule
